hynoc_prra_arbiter: RTL and testbench

Parallel round-robin arbiter for HyNoC router output ports. It grants one of WIDTH requesters per cycle and holds the grant while the winner keeps requesting. When the winner drops its request, it re-arbitrates with rotating priority starting after the last winner. All WIDTH priority rotations are evaluated in parallel (one decode per pointer value) and selected by the pointer register. The grant output is registered, with an optional extra output pipeline.

---
 rtl/hynoc_prra_arbiter.sv | 92 +++++++++
 tb/tb_hynoc_prra_arbiter.sv | 176 +++++++++++++++++
 2 files changed

// File: rtl/hynoc_prra_arbiter.sv
// Round-robin arbiter for HyNoC router output ports.
// Holds the grant while the owner keeps requesting; otherwise picks the first requester after the pointer.
module hynoc_prra_arbiter #(
  parameter int unsigned WIDTH      = 4,
  parameter int unsigned LOG2_WIDTH = 2,
  parameter int unsigned PIPELINE   = 0
) (
  input  logic                  clk,
  input  logic                  srst,
  input  logic [WIDTH-1:0]      request,
  output logic [LOG2_WIDTH-1:0] state,
  output logic [WIDTH-1:0]      grant
);

  logic [WIDTH-1:0]      g_int;
  logic [WIDTH-1:0]      g_nxt;
  logic [LOG2_WIDTH-1:0] ptr;
  logic [LOG2_WIDTH-1:0] ptr_nxt;
  logic [LOG2_WIDTH-1:0] dec_idx [WIDTH];
  logic [LOG2_WIDTH-1:0] sel_idx;
  logic                  hold;

  // One winner decode per pointer value; the search order is p+1, p+2, ..., p (mod WIDTH).
  always_comb begin
    for (int p = 0; p < WIDTH; p++) begin
      dec_idx[p] = LOG2_WIDTH'(p);
      for (int k = WIDTH; k >= 1; k--) begin
        if (request[(p + k) % WIDTH]) begin
          dec_idx[p] = LOG2_WIDTH'((p + k) % WIDTH);
        end
      end
    end
  end

  assign sel_idx = dec_idx[ptr];
  assign hold    = |(g_int & request);

  // The owner keeps the grant; otherwise the pointer-selected decode wins, or nobody when idle.
  always_comb begin
    g_nxt   = g_int;
    ptr_nxt = ptr;
    if (!hold) begin
      if (|request) begin
        g_nxt   = WIDTH'(1) << sel_idx;
        ptr_nxt = sel_idx;
      end else begin
        g_nxt   = '0;
      end
    end
  end

  // After reset the pointer sits at WIDTH-1 so requester 0 has top priority.
  always_ff @(posedge clk) begin
    if (srst) begin
      g_int <= '0;
      ptr   <= LOG2_WIDTH'(WIDTH - 1);
    end else begin
      g_int <= g_nxt;
      ptr   <= ptr_nxt;
    end
  end

  assign state = ptr;

  // Optional output delay; the arbitration loop itself stays single-cycle.
  if (PIPELINE == 0) begin : g_nopipe
    assign grant = g_int;
  end else begin : g_pipe
    logic [PIPELINE*WIDTH-1:0] pipe_q;

    if (PIPELINE == 1) begin : g_one
      always_ff @(posedge clk) begin
        if (srst) begin
          pipe_q <= '0;
        end else begin
          pipe_q <= g_int;
        end
      end
    end else begin : g_many
      always_ff @(posedge clk) begin
        if (srst) begin
          pipe_q <= '0;
        end else begin
          pipe_q <= {pipe_q[(PIPELINE-1)*WIDTH-1:0], g_int};
        end
      end
    end

    assign grant = pipe_q[PIPELINE*WIDTH-1 -: WIDTH];
  end

endmodule

// File: tb/tb_hynoc_prra_arbiter.sv
// Scoreboard bench for hynoc_prra_arbiter: directed plan rows plus randomized traffic,
// applied to a PIPELINE=0 and a PIPELINE=2 instance in parallel.
module tb_hynoc_prra_arbiter;

  localparam int unsigned WIDTH      = 4;
  localparam int unsigned LOG2_WIDTH = 2;

  logic                  clk;
  logic                  srst;
  logic [WIDTH-1:0]      request;
  logic [LOG2_WIDTH-1:0] state0;
  logic [LOG2_WIDTH-1:0] state2;
  logic [WIDTH-1:0]      grant0;
  logic [WIDTH-1:0]      grant2;

  int unsigned n_checks;
  int unsigned n_errors;
  int unsigned cyc;

  logic [WIDTH-1:0]      q_g0 [$];
  logic [WIDTH-1:0]      q_g2 [$];
  logic [LOG2_WIDTH-1:0] q_s  [$];

  logic [WIDTH-1:0]      m_g;
  logic [LOG2_WIDTH-1:0] m_ptr;

  hynoc_prra_arbiter #(.WIDTH(WIDTH), .LOG2_WIDTH(LOG2_WIDTH), .PIPELINE(0)) dut0 (
    .clk     (clk),
    .srst    (srst),
    .request (request),
    .state   (state0),
    .grant   (grant0)
  );

  hynoc_prra_arbiter #(.WIDTH(WIDTH), .LOG2_WIDTH(LOG2_WIDTH), .PIPELINE(2)) dut2 (
    .clk     (clk),
    .srst    (srst),
    .request (request),
    .state   (state2),
    .grant   (grant2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s cycle=%0d got=%0h exp=%0h", tag, cyc, got, exp);
    end
  endtask

  // Reference arbiter written straight from the rules: reset, hold, idle, rotating search.
  task automatic model_step(input logic rst, input logic [WIDTH-1:0] req);
    logic found;
    int   idx;
    if (rst) begin
      m_g   = '0;
      m_ptr = LOG2_WIDTH'(WIDTH - 1);
    end else if ((m_g & req) != '0) begin
      m_g = m_g;
    end else if (req == '0) begin
      m_g = '0;
    end else begin
      found = 1'b0;
      for (int k = 1; k <= WIDTH; k++) begin
        idx = (int'(m_ptr) + k) % WIDTH;
        if (!found && req[idx]) begin
          found = 1'b1;
          m_g   = '0;
          m_g[idx] = 1'b1;
          m_ptr = LOG2_WIDTH'(idx);
        end
      end
    end
  endtask

  // One clock: drive, push expectations, then pop and compare after the edge.
  task automatic cycle(input logic rst, input logic [WIDTH-1:0] req, input logic directed,
                       input logic [WIDTH-1:0] tg, input logic [LOG2_WIDTH-1:0] ts);
    logic [WIDTH-1:0]      eg;
    logic [LOG2_WIDTH-1:0] es;
    @(negedge clk);
    srst    = rst;
    request = req;
    model_step(rst, req);
    eg = directed ? tg : m_g;
    es = directed ? ts : m_ptr;
    if (rst) begin
      q_g2.delete();
      q_g2.push_back('0);
      q_g2.push_back('0);
    end
    q_g0.push_back(eg);
    q_g2.push_back(eg);
    q_s.push_back(es);
    @(posedge clk);
    #1;
    begin
      logic [LOG2_WIDTH-1:0] s_exp;
      s_exp = q_s.pop_front();
      check("grant_p0", 32'(grant0), 32'(q_g0.pop_front()));
      check("state_p0", 32'(state0), 32'(s_exp));
      check("grant_p2", 32'(grant2), 32'(q_g2.pop_front()));
      check("state_p2", 32'(state2), 32'(s_exp));
    end
    cyc++;
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    cyc      = 0;
    srst     = 1'b1;
    request  = '0;
    m_g      = '0;
    m_ptr    = '0;

    // Reset, then idle for 8 cycles.
    cycle(1'b1, 4'b0000, 1'b1, 4'b0000, 2'd3);
    cycle(1'b1, 4'b0000, 1'b1, 4'b0000, 2'd3);
    for (int i = 0; i < 8; i++) cycle(1'b0, 4'b0000, 1'b1, 4'b0000, 2'd3);
    cycle(1'b0, 4'b0100, 1'b1, 4'b0100, 2'd2);

    // Hold and re-arbitration, including wrap-around.
    cycle(1'b0, 4'b0110, 1'b1, 4'b0100, 2'd2);
    cycle(1'b0, 4'b0010, 1'b1, 4'b0010, 2'd1);
    cycle(1'b0, 4'b0111, 1'b1, 4'b0010, 2'd1);
    cycle(1'b0, 4'b0101, 1'b1, 4'b0100, 2'd2);
    cycle(1'b0, 4'b1001, 1'b1, 4'b1000, 2'd3);
    cycle(1'b0, 4'b0110, 1'b1, 4'b0010, 2'd1);

    // Idle keeps the pointer.
    for (int i = 0; i < 4; i++) cycle(1'b0, 4'b0000, 1'b1, 4'b0000, 2'd1);
    cycle(1'b0, 4'b1111, 1'b1, 4'b0100, 2'd2);

    // Rotation sequence.
    cycle(1'b0, 4'b1011, 1'b1, 4'b1000, 2'd3);
    cycle(1'b0, 4'b0011, 1'b1, 4'b0001, 2'd0);
    cycle(1'b0, 4'b0010, 1'b1, 4'b0010, 2'd1);
    cycle(1'b0, 4'b0000, 1'b1, 4'b0000, 2'd1);
    cycle(1'b0, 4'b1110, 1'b1, 4'b0100, 2'd2);
    cycle(1'b0, 4'b1010, 1'b1, 4'b1000, 2'd3);
    cycle(1'b0, 4'b0010, 1'b1, 4'b0010, 2'd1);

    // Reset while a grant is held.
    cycle(1'b0, 4'b1000, 1'b1, 4'b1000, 2'd3);
    cycle(1'b0, 4'b1000, 1'b1, 4'b1000, 2'd3);
    cycle(1'b1, 4'b1000, 1'b1, 4'b0000, 2'd3);
    cycle(1'b0, 4'b1001, 1'b1, 4'b0001, 2'd0);
    cycle(1'b0, 4'b0000, 1'b1, 4'b0000, 2'd0);

    // Randomized traffic with an owner-biased request pattern and sparse resets.
    for (int i = 0; i < 400; i++) begin
      logic [WIDTH-1:0] r;
      logic             rr;
      r = WIDTH'($urandom_range(0, 15));
      if ($urandom_range(0, 3) != 0) r = r | m_g;
      if ($urandom_range(0, 5) == 0) r = '0;
      rr = ($urandom_range(0, 49) == 0);
      cycle(rr, r, 1'b0, '0, '0);
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  // Safety net so the run can never hang.
  initial begin
    #200000;
    $display("FAIL timeout cycle=%0d got=running exp=finished", cyc);
    $fatal(1, "timeout");
  end

endmodule
